// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO fed by CPU stores, drained by a
// serialiser FSM whose line output is registered one cycle behind the FSM state.
module uart_tx_fifo #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          sys_clk_i,
   input  logic                          sys_rstn_i,
   input  logic                          uart_wr_i,
   input  logic [7:0]                    uart_dat_i,
   output logic                          uart_tx,
   output logic                          uart_full_o,
   output logic                          uart_empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   uart_count_o,
   output logic                          uart_busy_o,
   output logic                          uart_overflow_o
);

   // state | meaning
   // IDLE  | line high, waiting for a queued byte
   // START | start bit (line low) for one bit time
   // DATA  | eight data bits, LSB first
   // STOP  | stop bit (line high); chains straight into START if more bytes wait
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TMAX  = TW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q, ovf_q;

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          tx_q, busy_q;

   logic          push_ok, pop;

   always_comb begin
      push_ok = uart_wr_i && !full_q;
      pop     = !empty_q && ((state_q == IDLE) || (state_q == STOP && timer_q == '0));
      count_d = count_q;
      if (push_ok && !pop)
         count_d = count_q + CW'(1);
      else if (!push_ok && pop)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge sys_clk_i) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= uart_dat_i;
   end

   always_ff @(posedge sys_clk_i) begin
      if (!sys_rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         if (uart_wr_i && full_q)
            ovf_q <= 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == CFULL);
         empty_q <= (count_d == '0);
      end
   end

   // tx_q follows state_q with one cycle of lag, so every bit still lasts CLKS_PER_BIT cycles
   always_ff @(posedge sys_clk_i) begin
      if (!sys_rstn_i) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         tx_q <= (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  timer_q <= TMAX;
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (timer_q == '0) begin
                  timer_q   <= TMAX;
                  bit_idx_q <= '0;
                  state_q   <= DATA;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            DATA: begin
               if (timer_q == '0) begin
                  timer_q <= TMAX;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_idx_q == 3'd7)
                     state_q <= STOP;
                  else
                     bit_idx_q <= bit_idx_q + 3'd1;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            STOP: begin
               if (timer_q == '0) begin
                  if (pop) begin
                     shift_q <= mem_q[rd_ptr_q];
                     timer_q <= TMAX;
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign uart_tx         = tx_q;
   assign uart_full_o     = full_q;
   assign uart_empty_o    = empty_q;
   assign uart_count_o    = count_q;
   assign uart_busy_o     = busy_q;
   assign uart_overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4 and a 4-entry FIFO; frames are
// checked cycle by cycle against the expected 8N1 waveform.
module tb_uart_tx_fifo;

   logic       clk_sys = 1'b0;
   logic       rstn;
   logic       wr;
   logic [7:0] dat;
   logic       tx, full, empty, busy, ovf;
   logic [2:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_fifo #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .FIFO_DEPTH(4)) dut (
      .sys_clk_i       (clk_sys),
      .sys_rstn_i      (rstn),
      .uart_wr_i       (wr),
      .uart_dat_i      (dat),
      .uart_tx         (tx),
      .uart_full_o     (full),
      .uart_empty_o    (empty),
      .uart_count_o    (count),
      .uart_busy_o     (busy),
      .uart_overflow_o (ovf)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // called at a negedge; the byte is sampled at the next posedge, returns at the negedge after it
   task automatic push(input logic [7:0] d);
      wr  = 1'b1;
      dat = d;
      @(posedge clk_sys);
      @(negedge clk_sys);
      wr  = 1'b0;
   endtask

   // samples frame cycles c0..c1 on consecutive negedges, starting at the current one
   task automatic rx_frame(input string tag, input logic [7:0] exp, input int c0, input int c1);
      logic [9:0] fr;
      logic [7:0] got;
      int         bad;
      fr  = {1'b1, exp, 1'b0};
      got = '0;
      bad = 0;
      for (int c = c0; c <= c1; c++) begin
         if (c > c0) @(negedge clk_sys);
         if (tx !== fr[c/4]) bad++;
         if (c >= 4 && c <= 35 && (c % 4) == 2) got[(c-4)/4] = tx;
      end
      chk({tag, "_byte"}, got, exp);
      chk({tag, "_shape"}, bad, 0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tx"}, tx, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_empty"}, empty, 1);
   endtask

   initial begin
      logic [7:0] tab [9];
      int lows, busys;
      tab = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h99};
      rstn = 1'b0;
      wr   = 1'b0;
      dat  = '0;
      repeat (3) @(negedge clk_sys);
      chk("rst_tx", tx, 1);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      rstn = 1'b1;
      @(negedge clk_sys);

      // single byte, exact latency
      push(8'hA5);
      chk("t1_count", count, 1);
      chk("t1_tx_n0", tx, 1);
      @(negedge clk_sys);
      chk("t1_tx_n1", tx, 1);
      chk("t1_busy_n1", busy, 1);
      chk("t1_empty_n1", empty, 1);
      @(negedge clk_sys);
      rx_frame("t1", 8'hA5, 0, 39);
      @(negedge clk_sys);
      chk_idle("t1_end");

      // back-to-back frames
      push(8'h00);
      chk("t2_count_a", count, 1);
      push(8'hFF);
      chk("t2_count_b", count, 1);
      @(negedge clk_sys);
      rx_frame("t2_f0", 8'h00, 0, 39);
      @(negedge clk_sys);
      rx_frame("t2_f1", 8'hFF, 0, 39);
      @(negedge clk_sys);
      chk_idle("t2_end");

      // overflow
      for (int i = 0; i < 6; i++) begin
         push(8'h10 + 8'(i));
         if (i == 4) begin
            chk("t3_full4", full, 1);
            chk("t3_count4", count, 4);
            chk("t3_ovf4", ovf, 0);
         end
      end
      chk("t3_full5", full, 1);
      chk("t3_count5", count, 4);
      chk("t3_ovf5", ovf, 1);
      rx_frame("t3_f0", 8'h10, 3, 39);
      for (int k = 1; k < 5; k++) begin
         @(negedge clk_sys);
         rx_frame($sformatf("t3_f%0d", k), 8'h10 + 8'(k), 0, 39);
      end
      lows = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk_sys);
         if (tx !== 1'b1) lows++;
      end
      chk("t3_no_extra", lows, 0);
      chk_idle("t3_end");
      chk("t3_ovf_sticky", ovf, 1);

      // push coinciding with the STOP-expiry pop
      push(8'h31);
      push(8'h32);
      push(8'h33);
      chk("t4_count_pre", count, 2);
      rx_frame("t4_f0", 8'h31, 0, 38);
      wr  = 1'b1;
      dat = 8'h34;
      @(negedge clk_sys);
      wr  = 1'b0;
      chk("t4_count_pp", count, 2);
      chk("t4_stop_tx", tx, 1);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk_sys);
         rx_frame($sformatf("t4_f%0d", k), 8'h31 + 8'(k), 0, 39);
      end
      @(negedge clk_sys);
      chk_idle("t4_end");

      // reset during DATA bit 3
      push(8'h41);
      push(8'h42);
      push(8'h43);
      chk("t5_count_pre", count, 2);
      repeat (17) @(negedge clk_sys);
      chk("t5_bit3", tx, 0);
      rstn = 1'b0;
      @(negedge clk_sys);
      chk("t5_rst_tx", tx, 1);
      chk("t5_rst_empty", empty, 1);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_ovf", ovf, 0);
      chk("t5_rst_count", count, 0);
      rstn = 1'b1;
      lows  = 0;
      busys = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_sys);
         if (tx !== 1'b1) lows++;
         if (busy !== 1'b0) busys++;
      end
      chk("t5_quiet_tx", lows, 0);
      chk("t5_quiet_busy", busys, 0);

      // pointer wrap with spaced pushes
      for (int i = 0; i < 9; i++) begin
         push(tab[i]);
         @(negedge clk_sys);
         @(negedge clk_sys);
         rx_frame($sformatf("t6_b%0d", i), tab[i], 0, 39);
         repeat (6) @(negedge clk_sys);
      end
      chk_idle("t6_end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
